// File: rtl/err_metric_engine.sv
// rtl/err_metric_engine.sv - exhaustive operand sweep and error statistics for an approximate multiplier
// Optional macro ERR_METRIC_SQ_EN adds o_sum_sq_err (sum of squared error distance).
module err_metric_engine #(
    parameter int W      = 8,
    parameter int SIGNED = 1,
    parameter int LAT    = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic [W-1:0]     o_a,
    output logic [W-1:0]     o_b,
    input  logic [2*W-1:0]   i_exact,
    input  logic [2*W-1:0]   i_approx,
    output logic             o_busy,
    output logic             o_done,
    output logic [4*W+1:0]   o_sum_abs_err,
    output logic [2*W:0]     o_max_exact,
    output logic [2*W:0]     o_max_err,
    output logic [2*W:0]     o_err_cnt,
    output logic [2*W:0]     o_sample_cnt
`ifdef ERR_METRIC_SQ_EN
    ,
    output logic [6*W+1:0]   o_sum_sq_err
`endif
);

    localparam bit SX = (SIGNED != 0);
`ifdef ERR_METRIC_SQ_EN
    localparam int DRAIN_LEN = LAT + 3;
`else
    localparam int DRAIN_LEN = LAT + 2;
`endif
    localparam logic [3:0]   DRAIN_LAST = 4'(DRAIN_LEN - 1);
    // Flipping each operand MSB turns a plain counter into a -2^(W-1)..2^(W-1)-1 walk
    localparam logic [W-1:0] OPF = SX ? {1'b1, {(W-1){1'b0}}} : '0;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t         state, state_nx;
    logic [2*W-1:0] cnt, cnt_inc;
    logic [3:0]     drain_cnt;
    logic           last, issue_v, samp_v, clear;

    assign cnt_inc = cnt + (2*W)'(1);
    assign last    = &cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start) state_nx = SWEEP;
            SWEEP:   if (last) state_nx = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nx = DONE;
            DONE:    if (i_start) state_nx = SWEEP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (state == SWEEP) || (state == DRAIN);
        o_done  = (state == DONE);
        issue_v = (state == SWEEP);
        clear   = ((state == IDLE) || (state == DONE)) && i_start;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt       <= '0;
            o_a       <= '0;
            o_b       <= '0;
            drain_cnt <= '0;
        end else begin
            if (clear) begin
                cnt <= '0;
                o_a <= OPF;
                o_b <= OPF;
            end else if (issue_v && !last) begin
                cnt        <= cnt_inc;
                {o_a, o_b} <= cnt_inc ^ {OPF, OPF};
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
        end
    end

    // Per-pair valid bit delayed to line up with the external multipliers' outputs
    generate
        if (LAT == 0) begin : g_nolat
            assign samp_v = issue_v;
        end else begin : g_lat
            logic [LAT-1:0] vsr;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) vsr <= '0;
                else       vsr <= LAT'({vsr, issue_v});
            end
            assign samp_v = vsr[LAT-1];
        end
    endgenerate

    logic signed [2*W:0] ex_x, ap_x, diff_w;
    logic [2*W:0]        abs_diff, abs_ex;

    always_comb begin
        ex_x     = $signed({SX & i_exact[2*W-1], i_exact});
        ap_x     = $signed({SX & i_approx[2*W-1], i_approx});
        diff_w   = ap_x - ex_x;
        abs_diff = diff_w[2*W] ? $unsigned(-diff_w) : $unsigned(diff_w);
        abs_ex   = ex_x[2*W] ? $unsigned(-ex_x) : $unsigned(ex_x);
    end

    logic         s1_v, s1_ne;
    logic [2*W:0] s1_absd, s1_abse;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_v    <= 1'b0;
            s1_ne   <= 1'b0;
            s1_absd <= '0;
            s1_abse <= '0;
        end else begin
            s1_v <= samp_v;
            if (samp_v) begin
                s1_ne   <= (diff_w != '0);
                s1_absd <= abs_diff;
                s1_abse <= abs_ex;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sum_abs_err <= '0;
            o_max_exact   <= '0;
            o_max_err     <= '0;
            o_err_cnt     <= '0;
            o_sample_cnt  <= '0;
        end else if (clear) begin
            o_sum_abs_err <= '0;
            o_max_exact   <= '0;
            o_max_err     <= '0;
            o_err_cnt     <= '0;
            o_sample_cnt  <= '0;
        end else if (s1_v) begin
            o_sum_abs_err <= o_sum_abs_err + {{(2*W+1){1'b0}}, s1_absd};
            if (s1_abse > o_max_exact) o_max_exact <= s1_abse;
            if (s1_absd > o_max_err)   o_max_err   <= s1_absd;
            o_err_cnt     <= o_err_cnt + {{(2*W){1'b0}}, s1_ne};
            o_sample_cnt  <= o_sample_cnt + (2*W+1)'(1);
        end
    end

`ifdef ERR_METRIC_SQ_EN
    // Square gets its own register stage so the multiplier is off the accumulate path
    logic           sq_v;
    logic [4*W+1:0] sq;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sq_v         <= 1'b0;
            sq           <= '0;
            o_sum_sq_err <= '0;
        end else begin
            sq_v <= s1_v;
            sq   <= (4*W+2)'(s1_absd) * (4*W+2)'(s1_absd);
            if (clear)     o_sum_sq_err <= '0;
            else if (sq_v) o_sum_sq_err <= o_sum_sq_err + {{(2*W){1'b0}}, sq};
        end
    end
`endif

endmodule
